// File: rtl/updown_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter: converter state
// encoding, wrap/saturate mode constants and elaboration-time helpers.
// Optional feature macro used by the design: COUNTER_BCD_EN.
package updown_counter_param_pkg;

  // States of the sequential binary-to-BCD converter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Values for the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Number of bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Decimal digits needed to show the largest unsigned value of 'width' bits.
  function automatic int bcd_digits(input int width);
    int v;
    int d;
    v = (1 << width) - 1;
    d = 1;
    while (v >= 10) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle of the up/down counter. The master side drives the
// count controls and observes the count, flags and BCD readout; the slave side
// is the counter itself.
interface updown_counter_param_if #(
  parameter int WIDTH      = 8,
  parameter int BCD_DIGITS = 3
);

  logic                    en;
  logic                    up;
  logic                    down;
  logic                    hold;
  logic                    load;
  logic [WIDTH-1:0]        load_val;
  logic [WIDTH-1:0]        count;
  logic                    at_max;
  logic                    at_min;
  logic                    wrap;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    bcd_valid;

  modport master (
    output en, up, down, hold, load, load_val,
    input  count, at_max, at_min, wrap, bcd, bcd_valid
  );

  modport slave (
    input  en, up, down, hold, load, load_val,
    output count, at_max, at_min, wrap, bcd, bcd_valid
  );

endinterface

// File: rtl/updown_counter_param_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. A start pulse captures
// 'bin_i'; WIDTH shift cycles later the converter sits in DONE for one cycle
// with done_o high and the result on bcd_o. A start seen in DONE restarts
// immediately. Only built when COUNTER_BCD_EN is defined.
`ifdef COUNTER_BCD_EN
module bin2bcd_seq
  import updown_counter_param_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        bin_i,
  output logic [4*BCD_DIGITS-1:0] bcd_o,
  output logic                    done_o
);

  // Internal digit count never drops below what WIDTH needs, so the shift
  // chain cannot overflow even if the caller asks for fewer output digits.
  localparam int DIG = (BCD_DIGITS < bcd_digits(WIDTH)) ? bcd_digits(WIDTH) : BCD_DIGITS;
  localparam int CW  = clog2(WIDTH);

  conv_state_e      state_q;
  logic [WIDTH-1:0] bin_q;
  logic [4*DIG-1:0] acc_q;
  logic [4*DIG-1:0] adj;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  // Add-3 correction on every digit of 5 or more before the next shift.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned and no latch is inferred.
    adj = acc_q;
    for (int d = 0; d < DIG; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM with the shift datapath and a registered done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: registers take <= so every assignment here sees pre-edge values
      // regardless of statement order.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          acc_q <= {adj[4*DIG-2:0], bin_q[WIDTH-1]};
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_o  = acc_q[4*BCD_DIGITS-1:0];
  assign done_o = done_q;

endmodule
`endif

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, wrap or saturate
// at the bounds, parallel load, hold, terminal flags and a one-cycle wrap
// pulse. With COUNTER_BCD_EN defined, a sequential converter keeps a BCD copy
// of the count; otherwise bcd and bcd_valid are tied low.
module updown_counter_param
  import updown_counter_param_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MODULUS    = 256,
  parameter int SATURATE   = MODE_WRAP,
  parameter int BCD_DIGITS = 3
) (
  input logic                   clk,
  input logic                   rst,
  updown_counter_param_if.slave cnt_if
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam bit               SAT     = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   inc_ext;

  // Next count by priority: disable > load > hold > single-direction step.
  // The increment is formed one bit wider so reaching MODULUS is detected
  // rather than silently rolling over the register width.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    inc_ext = {1'b0, count_q} + (WIDTH + 1)'(1);
    if (cnt_if.en) begin
      if (cnt_if.load) begin
        count_d = ({1'b0, cnt_if.load_val} >= MOD_EXT) ? MAX_CNT : cnt_if.load_val;
      end else if (!cnt_if.hold && (cnt_if.up != cnt_if.down)) begin
        if (cnt_if.up) begin
          if (inc_ext >= MOD_EXT) begin
            if (SAT) begin
              count_d = MAX_CNT;
            end else begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = inc_ext[WIDTH-1:0];
          end
        end else begin
          if (count_q == '0) begin
            if (SAT) begin
              count_d = '0;
            end else begin
              count_d = MAX_CNT;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cnt_if.count  = count_q;
  assign cnt_if.wrap   = wrap_q;
  assign cnt_if.at_max = (count_q == MAX_CNT);
  assign cnt_if.at_min = (count_q == '0);

`ifdef COUNTER_BCD_EN
  logic                    conv_start;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic                    busy_q;
  logic                    valid_q;
  logic                    bcd_match;
  logic [WIDTH-1:0]        snap_q;
  logic [WIDTH-1:0]        last_q;
  logic [4*BCD_DIGITS-1:0] bcd_q;

  // bcd_valid is qualified against the live count, so it drops in the very
  // cycle the count moves away from the last converted value and never
  // advertises a stale bcd.
  assign bcd_match  = valid_q && (last_q == count_q);

  // Start from idle whenever the readout is out of date; in DONE, restart at
  // once if the count moved while the conversion was running.
  assign conv_start = (!busy_q && !bcd_match) || (conv_done && (snap_q != count_q));

  bin2bcd_seq #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (count_q),
    .bcd_o   (conv_bcd),
    .done_o  (conv_done)
  );

  // Snapshot on start, publish on a DONE whose snapshot still matches count.
  // Runs independently of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      snap_q  <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
    end else begin
      if (conv_start) begin
        busy_q  <= 1'b1;
        snap_q  <= count_q;
        valid_q <= 1'b0;
      end else if (conv_done) begin
        busy_q <= 1'b0;
      end
      if (conv_done && (snap_q == count_q)) begin
        bcd_q   <= conv_bcd;
        last_q  <= snap_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign cnt_if.bcd       = bcd_q;
  assign cnt_if.bcd_valid = bcd_match;
`else
  assign cnt_if.bcd       = '0;
  assign cnt_if.bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: four instances (mod-256 wrap, mod-10 wrap,
// mod-100 saturate, mod-256 saturate) share one stimulus stream and are
// compared every cycle against an arithmetic reference model. Directed
// sequences cover reset, wrap/saturate bounds, priority and clamping; a
// randomized phase follows. BCD readout checks depend on COUNTER_BCD_EN.
module tb_updown_counter_param;
  import updown_counter_param_pkg::*;

  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 4;

  function automatic int mod_of(input int g);
    case (g)
      0:       return 256;
      1:       return 10;
      2:       return 100;
      default: return 256;
    endcase
  endfunction

  function automatic int sat_of(input int g);
    return (g >= 2) ? MODE_SAT : MODE_WRAP;
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up, down, hold, load;
  logic [W-1:0] load_val;

  logic [W-1:0]   count_a     [N];
  logic           at_max_a    [N];
  logic           at_min_a    [N];
  logic           wrap_a      [N];
  logic [4*D-1:0] bcd_a       [N];
  logic           bcd_valid_a [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    updown_counter_param_if #(.WIDTH(W), .BCD_DIGITS(D)) bus ();

    assign bus.en       = en;
    assign bus.up       = up;
    assign bus.down     = down;
    assign bus.hold     = hold;
    assign bus.load     = load;
    assign bus.load_val = load_val;

    assign count_a[g]     = bus.count;
    assign at_max_a[g]    = bus.at_max;
    assign at_min_a[g]    = bus.at_min;
    assign wrap_a[g]      = bus.wrap;
    assign bcd_a[g]       = bus.bcd;
    assign bcd_valid_a[g] = bus.bcd_valid;

    updown_counter_param #(
      .WIDTH      (W),
      .MODULUS    (mod_of(g)),
      .SATURATE   (sat_of(g)),
      .BCD_DIGITS (D)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .cnt_if (bus.slave)
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_cnt  [N];
  bit m_wrap [N];
  int prev_m [N];
  int stable [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Advance the model by one clock edge from the current inputs.
  task automatic model_step();
    for (int g = 0; g < N; g++) begin
      int m;
      int c;
      bit w;
      m = mod_of(g);
      c = m_cnt[g];
      w = 1'b0;
      if (rst) begin
        c = 0;
      end else if (en) begin
        if (load) begin
          c = (int'(load_val) >= m) ? m - 1 : int'(load_val);
        end else if (!hold && up && !down) begin
          if (sat_of(g) == MODE_SAT) begin
            c = (c + 1 > m - 1) ? m - 1 : c + 1;
          end else begin
            w = (c + 1 == m);
            c = (c + 1) % m;
          end
        end else if (!hold && down && !up) begin
          if (sat_of(g) == MODE_SAT) begin
            c = (c == 0) ? 0 : c - 1;
          end else begin
            w = (c == 0);
            c = (c - 1 + m) % m;
          end
        end
      end
      m_cnt[g]  = c;
      m_wrap[g] = w;
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < N; g++) begin
      check($sformatf("count[%0d]", g),  32'(count_a[g]),  32'(m_cnt[g]));
      check($sformatf("wrap[%0d]", g),   32'(wrap_a[g]),   32'(m_wrap[g]));
      check($sformatf("at_max[%0d]", g), 32'(at_max_a[g]), 32'(m_cnt[g] == mod_of(g) - 1));
      check($sformatf("at_min[%0d]", g), 32'(at_min_a[g]), 32'(m_cnt[g] == 0));
`ifdef COUNTER_BCD_EN
      if (rst || m_cnt[g] != prev_m[g]) stable[g] = 0;
      else                              stable[g]++;
      prev_m[g] = m_cnt[g];
      if (bcd_valid_a[g]) begin
        check($sformatf("bcd_fresh[%0d]", g), 32'(bcd_a[g]), 32'(to_bcd(m_cnt[g])));
      end
      if (stable[g] >= 2*W + 2) begin
        check($sformatf("bcd_settled[%0d]", g), 32'(bcd_valid_a[g]), 32'd1);
      end
`else
      check($sformatf("bcd_tied[%0d]", g),       32'(bcd_a[g]),       32'd0);
      check($sformatf("bcd_valid_tied[%0d]", g), 32'(bcd_valid_a[g]), 32'd0);
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply(input bit r, input bit e, input bit u, input bit dn,
                       input bit h, input bit l, input logic [W-1:0] v);
    rst      = r;
    en       = e;
    up       = u;
    down     = dn;
    hold     = h;
    load     = l;
    load_val = v;
    cycle();
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      m_cnt[g]  = 0;
      m_wrap[g] = 1'b0;
      prev_m[g] = 0;
      stable[g] = 0;
    end

    // Reset held two cycles with up asserted.
    repeat (2) apply(1, 1, 1, 0, 0, 0, '0);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_count[%0d]", g),     32'(count_a[g]),     32'd0);
      check($sformatf("rst_wrap[%0d]", g),      32'(wrap_a[g]),      32'd0);
      check($sformatf("rst_bcd_valid[%0d]", g), 32'(bcd_valid_a[g]), 32'd0);
    end

    // Mod-10 up wrap: load 9, step up, pulse lasts one cycle.
    apply(0, 1, 0, 0, 0, 1, 8'd9);
    check("load9_m10", 32'(count_a[1]), 32'd9);
    apply(0, 1, 1, 0, 0, 0, '0);
    check("upwrap_count_m10", 32'(count_a[1]), 32'd0);
    check("upwrap_pulse_m10", 32'(wrap_a[1]),  32'd1);
    apply(0, 1, 0, 0, 0, 0, '0);
    check("upwrap_pulse_end", 32'(wrap_a[1]),  32'd0);

    // Mod-10 down wrap from 0.
    apply(0, 1, 0, 1, 0, 0, '0);
    check("dnwrap_count_m10", 32'(count_a[1]), 32'd9);
    check("dnwrap_pulse_m10", 32'(wrap_a[1]),  32'd1);
    apply(0, 1, 0, 0, 0, 0, '0);
    check("dnwrap_pulse_end", 32'(wrap_a[1]),  32'd0);

    // Saturate at 255.
    apply(0, 1, 0, 0, 0, 1, 8'd255);
    repeat (3) begin
      apply(0, 1, 1, 0, 0, 0, '0);
      check("sat_count_255", 32'(count_a[3]), 32'd255);
      check("sat_no_wrap",   32'(wrap_a[3]),  32'd0);
    end

    // Priority: load beats hold and up; hold beats up; up&down no-op; en=0 freezes.
    apply(0, 1, 1, 0, 1, 1, 8'd42);
    check("prio_load", 32'(count_a[0]), 32'd42);
    apply(0, 1, 1, 0, 1, 0, '0);
    check("prio_hold", 32'(count_a[0]), 32'd42);
    apply(0, 1, 1, 1, 0, 0, '0);
    check("prio_updown", 32'(count_a[0]), 32'd42);
    apply(0, 0, 0, 0, 0, 1, 8'd7);
    check("prio_en_off", 32'(count_a[0]), 32'd42);

    // Clamp on over-range load.
    apply(0, 1, 0, 0, 0, 1, 8'd200);
    check("clamp_m100",  32'(count_a[2]),  32'd99);
    check("clamp_atmax", 32'(at_max_a[2]), 32'd1);
    check("clamp_m10",   32'(count_a[1]),  32'd9);

`ifdef COUNTER_BCD_EN
    // Let every converter settle, then time a fresh conversion of 255.
    repeat (2*W + 4) apply(0, 1, 0, 0, 0, 0, '0);
    apply(0, 1, 0, 0, 0, 1, 8'd255);
    for (int k = 0; k < W + 2 && !bcd_valid_a[0]; k++) apply(0, 1, 0, 0, 0, 0, '0);
    check("bcd_latency_255", 32'(bcd_valid_a[0]), 32'd1);
    check("bcd_value_255",   32'(bcd_a[0]),       32'h255);

    // Move the count while a conversion is shifting.
    apply(0, 1, 0, 0, 0, 1, 8'd123);
    repeat (3) apply(0, 1, 0, 0, 0, 0, '0);
    apply(0, 1, 0, 0, 0, 1, 8'd45);
    repeat (2*W + 4) apply(0, 1, 0, 0, 0, 0, '0);
    check("bcd_restart_valid", 32'(bcd_valid_a[0]), 32'd1);
    check("bcd_restart_value", 32'(bcd_a[0]),       32'h045);
`endif

    // Randomized phase with occasional quiet stretches.
    for (int i = 0; i < 1500; i++) begin
      bit r, e, u, dn, h, l;
      logic [W-1:0] v;
      if ($urandom_range(0, 39) == 0) begin
        repeat (2*W + 4) apply(0, 1, 0, 0, 0, 0, '0);
        continue;
      end
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 7) != 0);
      u  = ($urandom_range(0, 1) == 1);
      dn = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 5) == 0);
      l  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 6))
        0:       v = 8'd0;
        1:       v = 8'd9;
        2:       v = 8'd99;
        3:       v = 8'd100;
        4:       v = 8'd255;
        default: v = W'($urandom_range(0, 255));
      endcase
      apply(r, e, u, dn, h, l, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
